// File: rtl/ctr_drbg_pkg.sv
// Shared types and default widths for the CTR_DRBG sequencing controller.
package ctr_drbg_pkg;

  localparam int unsigned DefBlockLen = 128;
  localparam int unsigned DefKeyLen   = 128;
  localparam int unsigned DefSeedLen  = 256;

  typedef enum logic [1:0] {
    OpInstantiate = 2'd0,
    OpReseed      = 2'd1,
    OpGenerate    = 2'd2,
    OpReserved    = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    StatusOk              = 2'd0,
    StatusReseedRequired  = 2'd1,
    StatusNotInstantiated = 2'd2,
    StatusBadCmd          = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    StIdle,
    StGenReq,
    StGenOut,
    StUpdReq,
    StUpdFin,
    StDone
  } state_e;

endpackage

// File: rtl/ctr_drbg_update_seq.sv
// Update loop: encrypts V+1..V+n into the temp register, then XORs in the provided data
// and splits the result into the next Key and V.
module ctr_drbg_update_seq
  import ctr_drbg_pkg::*;
#(
  parameter int unsigned BLOCKLEN = DefBlockLen,
  parameter int unsigned KEYLEN   = DefKeyLen,
  parameter int unsigned SEEDLEN  = DefSeedLen
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BLOCKLEN-1:0] v_in,
  input  logic [SEEDLEN-1:0]  pd,
  output logic                busy,
  output logic                fin,
  output logic                enc_req,
  output logic [BLOCKLEN-1:0] enc_v,
  input  logic                enc_ack,
  input  logic [BLOCKLEN-1:0] enc_result,
  output logic [KEYLEN-1:0]   new_key,
  output logic [BLOCKLEN-1:0] new_v
);

  localparam int unsigned NumBlk = SEEDLEN / BLOCKLEN;
  localparam int unsigned CntW   = (NumBlk > 1) ? $clog2(NumBlk) : 1;

  logic [CntW-1:0]     cnt_q;
  logic                req_q;
  logic                gap_q;
  logic [BLOCKLEN-1:0] v_q;
  logic [SEEDLEN-1:0]  temp_q;
  logic [SEEDLEN-1:0]  seed_mix;
  logic                last;

  assign last = (cnt_q == CntW'(NumBlk - 1));

  // gap_q gives the one idle cycle between an ack and the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      req_q  <= 1'b0;
      gap_q  <= 1'b0;
      v_q    <= '0;
      temp_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
      req_q <= 1'b1;
      gap_q <= 1'b0;
      v_q   <= v_in + BLOCKLEN'(1);
    end else if (req_q && enc_ack) begin
      temp_q[SEEDLEN - 1 - int'(cnt_q) * BLOCKLEN -: BLOCKLEN] <= enc_result;
      req_q <= 1'b0;
      if (!last) begin
        gap_q <= 1'b1;
        cnt_q <= cnt_q + CntW'(1);
        v_q   <= v_q + BLOCKLEN'(1);
      end
    end else if (gap_q) begin
      gap_q <= 1'b0;
      req_q <= 1'b1;
    end
  end

  assign busy     = req_q | gap_q;
  assign fin      = req_q & enc_ack & last;
  assign enc_req  = req_q;
  assign enc_v    = v_q;
  assign seed_mix = temp_q ^ pd;
  assign new_key  = seed_mix[SEEDLEN-1 -: KEYLEN];
  assign new_v    = seed_mix[BLOCKLEN-1:0];

endmodule

// File: rtl/ctr_drbg_ctrl.sv
// CTR_DRBG sequencing controller: Instantiate / Reseed / Generate over an external cipher.
// Optional macro ADDIN_EN enables additional input on Generate (pre- and post-update).
module ctr_drbg_ctrl
  import ctr_drbg_pkg::*;
#(
  parameter int unsigned BLOCKLEN     = DefBlockLen,
  parameter int unsigned KEYLEN       = DefKeyLen,
  parameter int unsigned SEEDLEN      = DefSeedLen,
  parameter int unsigned RESEED_LIMIT = 1024,
  parameter int unsigned MAX_BLOCKS   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_op,
  input  logic [SEEDLEN-1:0]                cmd_data,
  input  logic [$clog2(MAX_BLOCKS+1)-1:0]   cmd_nblocks,
  output logic                              enc_req,
  output logic [KEYLEN-1:0]                 enc_key,
  output logic [BLOCKLEN-1:0]               enc_v,
  input  logic                              enc_ack,
  input  logic [BLOCKLEN-1:0]               enc_result,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BLOCKLEN-1:0]               out_data,
  output logic                              done,
  output logic [1:0]                        status,
  output logic                              instantiated
);

  localparam int unsigned NbW  = $clog2(MAX_BLOCKS + 1);
  localparam int unsigned CtrW = $clog2(RESEED_LIMIT + 2);

  if ((SEEDLEN % BLOCKLEN) != 0 || SEEDLEN != KEYLEN + BLOCKLEN) begin : g_param_err
    $error("ctr_drbg_ctrl: SEEDLEN must be a multiple of BLOCKLEN and equal KEYLEN+BLOCKLEN");
  end

  state_e              state_q, state_d;
  cmd_op_e             op_q, op_d;
  status_e             status_q, status_d;
  logic [KEYLEN-1:0]   key_q, key_d;
  logic [BLOCKLEN-1:0] v_q, v_d;
  logic [CtrW-1:0]     ctr_q, ctr_d;
  logic                inst_q, inst_d;
  logic                pre_q, pre_d;
  logic [SEEDLEN-1:0]  data_q, data_d;
  logic [NbW-1:0]      nb_q, nb_d;
  logic [NbW-1:0]      blk_q, blk_d;
  logic [BLOCKLEN-1:0] out_data_q, out_data_d;

  logic                upd_start, upd_busy, upd_fin, upd_enc_req;
  logic [BLOCKLEN-1:0] upd_enc_v, upd_new_v;
  logic [KEYLEN-1:0]   upd_new_key;
  logic [SEEDLEN-1:0]  addin, upd_pd;
  logic                pre_upd;

`ifdef ADDIN_EN
  assign addin   = data_q;
  assign pre_upd = |cmd_data;
`else
  assign addin   = '0;
  assign pre_upd = 1'b0;
`endif

  assign upd_pd = (op_q == OpGenerate) ? addin : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OpInstantiate;
      status_q   <= StatusOk;
      key_q      <= '0;
      v_q        <= '0;
      ctr_q      <= '0;
      inst_q     <= 1'b0;
      pre_q      <= 1'b0;
      data_q     <= '0;
      nb_q       <= '0;
      blk_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      status_q   <= status_d;
      key_q      <= key_d;
      v_q        <= v_d;
      ctr_q      <= ctr_d;
      inst_q     <= inst_d;
      pre_q      <= pre_d;
      data_q     <= data_d;
      nb_q       <= nb_d;
      blk_q      <= blk_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    status_d   = status_q;
    key_d      = key_q;
    v_d        = v_q;
    ctr_d      = ctr_q;
    inst_d     = inst_q;
    pre_d      = pre_q;
    data_d     = data_q;
    nb_d       = nb_q;
    blk_d      = blk_q;
    out_data_d = out_data_q;
    upd_start  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d     = cmd_op_e'(cmd_op);
          data_d   = cmd_data;
          nb_d     = cmd_nblocks;
          blk_d    = '0;
          status_d = StatusOk;
          if (cmd_op_e'(cmd_op) == OpReserved) begin
            status_d = StatusBadCmd;
            state_d  = StDone;
          end else if (cmd_op_e'(cmd_op) == OpGenerate) begin
            if (!inst_q) begin
              status_d = StatusNotInstantiated;
              state_d  = StDone;
            end else if (32'(ctr_q) > RESEED_LIMIT) begin
              status_d = StatusReseedRequired;
              state_d  = StDone;
            end else if (32'(cmd_nblocks) > MAX_BLOCKS) begin
              status_d = StatusBadCmd;
              state_d  = StDone;
            end else if (pre_upd) begin
              pre_d     = 1'b1;
              upd_start = 1'b1;
              state_d   = StUpdReq;
            end else if (cmd_nblocks == '0) begin
              upd_start = 1'b1;
              state_d   = StUpdReq;
            end else begin
              v_d     = v_q + BLOCKLEN'(1);
              state_d = StGenReq;
            end
          end else begin
            if (cmd_op_e'(cmd_op) == OpInstantiate) begin
              key_d = '0;
              v_d   = '0;
            end
            upd_start = 1'b1;
            state_d   = StUpdReq;
          end
        end
      end
      StGenReq: begin
        if (enc_ack) begin
          out_data_d = enc_result;
          state_d    = StGenOut;
        end
      end
      StGenOut: begin
        if (out_ready) begin
          blk_d = blk_q + NbW'(1);
          if (blk_d == nb_q) begin
            upd_start = 1'b1;
            state_d   = StUpdReq;
          end else begin
            v_d     = v_q + BLOCKLEN'(1);
            state_d = StGenReq;
          end
        end
      end
      StUpdReq: begin
        if (upd_fin) state_d = StUpdFin;
      end
      StUpdFin: begin
        key_d = upd_new_key;
        v_d   = upd_new_v;
        if (pre_q) begin
          // Pre-generate update finished; proceed to output or straight to post-update.
          pre_d = 1'b0;
          if (nb_q == '0) begin
            upd_start = 1'b1;
            state_d   = StUpdReq;
          end else begin
            v_d     = upd_new_v + BLOCKLEN'(1);
            state_d = StGenReq;
          end
        end else begin
          unique case (op_q)
            OpInstantiate: begin
              ctr_d  = CtrW'(1);
              inst_d = 1'b1;
            end
            OpReseed:   ctr_d = CtrW'(1);
            OpGenerate: if (ctr_q != '1) ctr_d = ctr_q + CtrW'(1);
            default:    ctr_d = ctr_q;
          endcase
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  ctr_drbg_update_seq #(
    .BLOCKLEN (BLOCKLEN),
    .KEYLEN   (KEYLEN),
    .SEEDLEN  (SEEDLEN)
  ) u_update_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (upd_start),
    .v_in       (v_d),
    .pd         (upd_pd),
    .busy       (upd_busy),
    .fin        (upd_fin),
    .enc_req    (upd_enc_req),
    .enc_v      (upd_enc_v),
    .enc_ack    (enc_ack),
    .enc_result (enc_result),
    .new_key    (upd_new_key),
    .new_v      (upd_new_v)
  );

  assign cmd_ready    = (state_q == StIdle);
  assign enc_req      = (state_q == StGenReq) | upd_enc_req;
  assign enc_key      = key_q;
  assign enc_v        = upd_busy ? upd_enc_v : v_q;
  assign out_valid    = (state_q == StGenOut);
  assign out_data     = out_data_q;
  assign done         = (state_q == StDone);
  assign status       = done ? status_q : 2'd0;
  assign instantiated = inst_q;

endmodule

// File: tb/tb_ctr_drbg_ctrl.sv
// Directed bench for ctr_drbg_ctrl with a toy cipher E(K,V)=K^V acking 3 cycles after req.
module tb_ctr_drbg_ctrl;

  localparam int unsigned BL  = 128;
  localparam int unsigned KL  = 128;
  localparam int unsigned SL  = 256;
  localparam int unsigned RL  = 2;
  localparam int unsigned MB  = 16;
  localparam int unsigned NBW = $clog2(MB + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_op = 2'd0;
  logic [SL-1:0]  cmd_data = '0;
  logic [NBW-1:0] cmd_nblocks = '0;
  logic           enc_req;
  logic [KL-1:0]  enc_key;
  logic [BL-1:0]  enc_v;
  logic           enc_ack = 1'b0;
  logic [BL-1:0]  enc_result = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [BL-1:0]  out_data;
  logic           done;
  logic [1:0]     status;
  logic           instantiated;

  int checks = 0;
  int fails  = 0;

  logic [BL-1:0] vlog[$];
  logic [KL-1:0] klog[$];
  logic [BL-1:0] olog[$];
  int            ack_cnt = 0;

  always #5 clk = ~clk;

  ctr_drbg_ctrl #(
    .BLOCKLEN     (BL),
    .KEYLEN       (KL),
    .SEEDLEN      (SL),
    .RESEED_LIMIT (RL),
    .MAX_BLOCKS   (MB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_nblocks  (cmd_nblocks),
    .enc_req      (enc_req),
    .enc_key      (enc_key),
    .enc_v        (enc_v),
    .enc_ack      (enc_ack),
    .enc_result   (enc_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .done         (done),
    .status       (status),
    .instantiated (instantiated)
  );

  // Cipher model and output collector.
  always @(negedge clk) begin
    if (!rst_n) begin
      enc_ack = 1'b0;
      ack_cnt = 0;
    end else begin
      if (out_valid && out_ready) olog.push_back(out_data);
      if (enc_ack) begin
        enc_ack = 1'b0;
        ack_cnt = 0;
      end else if (enc_req) begin
        if (ack_cnt == 2) begin
          enc_ack    = 1'b1;
          enc_result = enc_key ^ enc_v;
          vlog.push_back(enc_v);
          klog.push_back(enc_key);
        end else begin
          ack_cnt++;
        end
      end
    end
  end

  task automatic clear_logs();
    vlog.delete();
    klog.delete();
    olog.delete();
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [SL-1:0] data, input int nb);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_data    = data;
    cmd_nblocks = NBW'(nb);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int lat,
                           output logic [1:0] st);
    lat = 0;
    st  = 2'bxx;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < budget);
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done: done not seen within %0d cycles", name, budget);
    end else begin
      st = status;
      checks++;
      if (cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s_ready_in_done: cmd_ready=%0b required 0", name, cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        fails++;
        $display("FAIL %s_after_done: done=%0b cmd_ready=%0b required 0/1", name, done, cmd_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({enc_req, out_valid, done, status, instantiated} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: req/valid/done/status/inst=%b required 000000",
               {enc_req, out_valid, done, status, instantiated});
    end
    checks++;
    if ({enc_key, enc_v, out_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: key=%h v=%h out=%h required 0", enc_key, enc_v, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  task automatic test_not_instantiated(input string name);
    int lat;
    logic [1:0] st;
    clear_logs();
    issue_cmd(2'd2, '0, 1);
    wait_done(name, 10, lat, st);
    checks++;
    if (lat > 2 || st !== 2'd2) begin
      fails++;
      $display("FAIL %s: latency=%0d status=%0d required <=2 / 2", name, lat, st);
    end
    checks++;
    if (vlog.size() != 0) begin
      fails++;
      $display("FAIL %s_noreq: enc requests=%0d required 0", name, vlog.size());
    end
  endtask

  task automatic test_instantiate();
    int lat;
    logic [1:0] st;
    clear_logs();
    issue_cmd(2'd0, '0, 0);
    wait_done("inst", 100, lat, st);
    checks++;
    if (st !== 2'd0 || instantiated !== 1'b1) begin
      fails++;
      $display("FAIL inst_status: status=%0d inst=%0b required 0/1", st, instantiated);
    end
    checks++;
    if (vlog.size() != 2 || vlog[0] !== BL'(1) || vlog[1] !== BL'(2) || klog[0] !== '0) begin
      fails++;
      $display("FAIL inst_enc: n=%0d v0=%h v1=%h k0=%h required 2/1/2/0",
               vlog.size(), vlog[0], vlog[1], klog[0]);
    end
  endtask

  task automatic test_bad_cmd();
    int lat;
    logic [1:0] st;
    clear_logs();
    issue_cmd(2'd3, '0, 1);
    wait_done("bad_op", 10, lat, st);
    checks++;
    if (st !== 2'd3 || vlog.size() != 0) begin
      fails++;
      $display("FAIL bad_op: status=%0d reqs=%0d required 3/0", st, vlog.size());
    end
    issue_cmd(2'd2, '0, 17);
    wait_done("bad_nblk", 10, lat, st);
    checks++;
    if (st !== 2'd3 || vlog.size() != 0 || instantiated !== 1'b1) begin
      fails++;
      $display("FAIL bad_nblk: status=%0d reqs=%0d inst=%0b required 3/0/1",
               st, vlog.size(), instantiated);
    end
  endtask

  task automatic test_generate();
    int lat;
    logic [1:0] st;
    clear_logs();
    issue_cmd(2'd2, '0, 2);
    wait_done("gen", 200, lat, st);
    checks++;
    if (st !== 2'd0 || olog.size() != 2 || olog[0] !== BL'(2) || olog[1] !== BL'(5)) begin
      fails++;
      $display("FAIL gen_out: status=%0d n=%0d o0=%h o1=%h required 0/2/2/5",
               st, olog.size(), olog[0], olog[1]);
    end
    checks++;
    if (vlog.size() != 4 || vlog[0] !== BL'(3) || vlog[1] !== BL'(4) || vlog[2] !== BL'(5) ||
        vlog[3] !== BL'(6) || klog[0] !== KL'(1)) begin
      fails++;
      $display("FAIL gen_enc: n=%0d v=%h,%h,%h,%h k0=%h required 4/3,4,5,6/1",
               vlog.size(), vlog[0], vlog[1], vlog[2], vlog[3], klog[0]);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int w;
    int bad;
    logic [1:0] st;
    logic [BL-1:0] d0;
    clear_logs();
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue_cmd(2'd2, '0, 2);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 100);
    d0 = out_data;
    checks++;
    if (out_valid !== 1'b1 || d0 !== BL'(12)) begin
      fails++;
      $display("FAIL bp_first: valid=%0b data=%h required 1/c", out_valid, d0);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_data !== d0 || out_valid !== 1'b1 || enc_req !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: unstable cycles=%0d required 0", bad);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done("bp", 200, lat, st);
    checks++;
    if (st !== 2'd0 || olog.size() != 2 || olog[0] !== BL'(12) || olog[1] !== BL'(13)) begin
      fails++;
      $display("FAIL bp_out: status=%0d n=%0d o0=%h o1=%h required 0/2/c/d",
               st, olog.size(), olog[0], olog[1]);
    end
    checks++;
    if (vlog.size() != 4 || vlog[0] !== BL'(8) || vlog[3] !== BL'(11)) begin
      fails++;
      $display("FAIL bp_enc: n=%0d v0=%h v3=%h required 4/8/b", vlog.size(), vlog[0], vlog[3]);
    end
  endtask

  task automatic test_reseed_limit();
    int lat;
    logic [1:0] st;
    logic [SL-1:0] seed;
    clear_logs();
    issue_cmd(2'd2, '0, 1);
    wait_done("limit", 10, lat, st);
    checks++;
    if (st !== 2'd1 || vlog.size() != 0) begin
      fails++;
      $display("FAIL limit: status=%0d reqs=%0d required 1/0", st, vlog.size());
    end
    // Seed chosen so the reseeded V becomes all-ones.
    seed = {128'h0, ~128'h1f};
    clear_logs();
    issue_cmd(2'd1, seed, 0);
    wait_done("reseed", 100, lat, st);
    checks++;
    if (st !== 2'd0 || vlog.size() != 2 || vlog[0] !== BL'(16) || vlog[1] !== BL'(17) ||
        klog[0] !== KL'(14)) begin
      fails++;
      $display("FAIL reseed: status=%0d n=%0d v0=%h v1=%h k0=%h required 0/2/10/11/e",
               st, vlog.size(), vlog[0], vlog[1], klog[0]);
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [1:0] st;
    clear_logs();
    issue_cmd(2'd2, '0, 0);
    wait_done("wrap", 100, lat, st);
    checks++;
    if (st !== 2'd0 || olog.size() != 0 || vlog.size() != 2 || vlog[0] !== '0 ||
        vlog[1] !== BL'(1) || klog[0] !== KL'(30)) begin
      fails++;
      $display("FAIL wrap: status=%0d outs=%0d n=%0d v0=%h v1=%h k0=%h required 0/0/2/0/1/1e",
               st, olog.size(), vlog.size(), vlog[0], vlog[1], klog[0]);
    end
    clear_logs();
    issue_cmd(2'd2, '0, 1);
    wait_done("gen_after_reseed", 200, lat, st);
    checks++;
    if (st !== 2'd0 || olog.size() != 1 || olog[0] !== BL'(62) || vlog[0] !== BL'(32)) begin
      fails++;
      $display("FAIL gen_after_reseed: status=%0d n=%0d o0=%h v0=%h required 0/1/3e/20",
               st, olog.size(), olog[0], vlog[0]);
    end
  endtask

  task automatic test_reset_mid_update();
    int w;
    clear_logs();
    issue_cmd(2'd1, '0, 0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!enc_req && w < 20);
    checks++;
    if (enc_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_req: enc_req=%0b required 1", enc_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({enc_req, out_valid, done, status, instantiated} !== 6'b0) begin
      fails++;
      $display("FAIL rst_mid_ctrl: req/valid/done/status/inst=%b required 000000",
               {enc_req, out_valid, done, status, instantiated});
    end
    checks++;
    if ({enc_key, enc_v, out_data} !== '0) begin
      fails++;
      $display("FAIL rst_mid_data: key=%h v=%h out=%h required 0", enc_key, enc_v, out_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    test_not_instantiated("post_reset_gen");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_not_instantiated("gen_uninst");
    test_instantiate();
    test_bad_cmd();
    test_generate();
    test_backpressure();
    test_reseed_limit();
    test_wrap();
    test_reset_mid_update();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
